// File: rtl/weight_stabilizer.sv
// Load-cell sample qualifier: turns raw samples into one settled weight per package.
// Optional WEIGHT_AVG_EN: the weight becomes the mean of the matching run instead of its first sample.
module weight_stabilizer #(
  parameter int W              = 12,
  parameter int SETTLE_N       = 4,
  parameter int TOL            = 4,
  parameter int EMPTY_TH       = 8,
  parameter int EMPTY_N        = 2,
  parameter int SETTLE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  output logic [W-1:0] weight,
  output logic         weight_valid,
  output logic         pkg_done,
  output logic         unstable_err,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_SETTLING = 2'd1,
    S_STABLE   = 2'd2,
    S_DEPART   = 2'd3
  } state_t;

  localparam int MW = $clog2(SETTLE_N + 1);
  localparam int TW = $clog2(SETTLE_TIMEOUT + 1);
  localparam int EW = $clog2(EMPTY_N + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(SETTLE_N);
  localparam logic [TW-1:0] TMO_MAX   = TW'(SETTLE_TIMEOUT);
  localparam logic [EW-1:0] EMPTY_MAX = EW'(EMPTY_N);

  state_t         state_q, state_d;
  logic [W-1:0]   ref_q, ref_d;
  logic [MW-1:0]  match_cnt_q, match_cnt_d, match_inc;
  logic [TW-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [EW-1:0]  empty_cnt_q, empty_cnt_d, empty_inc;
  logic [W-1:0]   weight_q, weight_d;
  logic           weight_valid_q, weight_valid_d;
  logic           pkg_done_q, pkg_done_d;
  logic           unstable_err_q, unstable_err_d;
  logic           is_empty, in_tol, settle;
  logic [W:0]     diff;
  logic [W-1:0]   settled_w;

`ifdef WEIGHT_AVG_EN
  localparam int LG = $clog2(SETTLE_N);
  localparam int AW = W + LG;
  logic [AW-1:0] acc_q, acc_d, acc_sum;

  assign acc_sum   = acc_q + AW'(sample);
  assign settled_w = acc_sum[AW-1:LG];
`else
  assign settled_w = ref_q;
`endif

  assign is_empty  = sample < W'(EMPTY_TH);
  assign diff      = (sample >= ref_q) ? ({1'b0, sample} - {1'b0, ref_q})
                                       : ({1'b0, ref_q} - {1'b0, sample});
  assign in_tol    = diff <= (W+1)'(TOL);
  assign match_inc = (match_cnt_q == MATCH_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
  assign tmo_inc   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
  assign empty_inc = (empty_cnt_q == EMPTY_MAX) ? empty_cnt_q : empty_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    match_cnt_d    = match_cnt_q;
    tmo_d          = tmo_q;
    empty_cnt_d    = empty_cnt_q;
    weight_d       = weight_q;
    weight_valid_d = weight_valid_q;
    pkg_done_d     = 1'b0;
    unstable_err_d = 1'b0;
    settle         = 1'b0;
`ifdef WEIGHT_AVG_EN
    acc_d          = acc_q;
`endif
    if (sample_valid) begin
      unique case (state_q)
        S_EMPTY: begin
          if (!is_empty) begin
            state_d     = S_SETTLING;
            ref_d       = sample;
            match_cnt_d = MW'(1);
            tmo_d       = TW'(1);
            empty_cnt_d = '0;
`ifdef WEIGHT_AVG_EN
            acc_d       = AW'(sample);
`endif
          end
        end
        S_SETTLING: begin
          if (is_empty) begin
            state_d     = S_EMPTY;
            ref_d       = '0;
            match_cnt_d = '0;
            tmo_d       = '0;
`ifdef WEIGHT_AVG_EN
            acc_d       = '0;
`endif
          end else begin
            tmo_d = tmo_inc;
            if (in_tol) begin
              match_cnt_d = match_inc;
`ifdef WEIGHT_AVG_EN
              acc_d       = acc_sum;
`endif
              settle      = (match_inc == MATCH_MAX);
            end else begin
              ref_d       = sample;
              match_cnt_d = MW'(1);
`ifdef WEIGHT_AVG_EN
              acc_d       = AW'(sample);
`endif
            end
            // Settle completion takes precedence over a simultaneous timeout.
            if (settle) begin
              state_d        = S_STABLE;
              weight_d       = settled_w;
              weight_valid_d = 1'b1;
              match_cnt_d    = '0;
              tmo_d          = '0;
            end else if (tmo_inc == TMO_MAX) begin
              state_d        = S_DEPART;
              unstable_err_d = 1'b1;
              match_cnt_d    = '0;
              tmo_d          = '0;
            end
          end
        end
        S_STABLE, S_DEPART: begin
          if (is_empty) begin
            empty_cnt_d = empty_inc;
            if (empty_inc == EMPTY_MAX) begin
              state_d        = S_EMPTY;
              empty_cnt_d    = '0;
              weight_d       = '0;
              weight_valid_d = 1'b0;
              pkg_done_d     = (state_q == S_STABLE);
            end
          end else begin
            empty_cnt_d = '0;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_EMPTY;
      ref_q          <= '0;
      match_cnt_q    <= '0;
      tmo_q          <= '0;
      empty_cnt_q    <= '0;
      weight_q       <= '0;
      weight_valid_q <= 1'b0;
      pkg_done_q     <= 1'b0;
      unstable_err_q <= 1'b0;
`ifdef WEIGHT_AVG_EN
      acc_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      match_cnt_q    <= match_cnt_d;
      tmo_q          <= tmo_d;
      empty_cnt_q    <= empty_cnt_d;
      weight_q       <= weight_d;
      weight_valid_q <= weight_valid_d;
      pkg_done_q     <= pkg_done_d;
      unstable_err_q <= unstable_err_d;
`ifdef WEIGHT_AVG_EN
      acc_q          <= acc_d;
`endif
    end
  end

  assign weight       = weight_q;
  assign weight_valid = weight_valid_q;
  assign pkg_done     = pkg_done_q;
  assign unstable_err = unstable_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_weight_stabilizer.sv
// Scoreboard bench for weight_stabilizer: a behavioural model pushes the expected
// outputs for each driven cycle, which are popped and compared one edge later.
module tb_weight_stabilizer;
  localparam int W = 12, SETTLE_N = 4, TOL = 4, EMPTY_TH = 8, EMPTY_N = 2, SETTLE_TIMEOUT = 64;
`ifdef WEIGHT_AVG_EN
  localparam int AVG = 1;
`else
  localparam int AVG = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample = '0;
  logic [W-1:0] weight;
  logic         weight_valid, pkg_done, unstable_err;
  logic [1:0]   state_dbg;

  weight_stabilizer dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .weight(weight), .weight_valid(weight_valid), .pkg_done(pkg_done),
    .unstable_err(unstable_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] w;
    logic         wv;
    logic         pd;
    logic         ue;
    logic [1:0]   st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pd_cnt, ue_cnt;

  // reference model state
  int m_st = 0, m_ref = 0, m_mc = 0, m_tmo = 0, m_ec = 0, m_sum = 0, m_w = 0, m_wv = 0;

  function automatic void model(input bit rst, input bit v, input int s);
    int   d;
    exp_t e;
    bit   pd = 0, ue = 0;
    if (rst) begin
      m_st = 0; m_ref = 0; m_mc = 0; m_tmo = 0; m_ec = 0; m_sum = 0; m_w = 0; m_wv = 0;
    end else if (v) begin
      case (m_st)
        0: if (s >= EMPTY_TH) begin
             m_st = 1; m_ref = s; m_mc = 1; m_tmo = 1; m_sum = s;
           end
        1: if (s < EMPTY_TH) begin
             m_st = 0; m_mc = 0; m_tmo = 0;
           end else begin
             m_tmo++;
             d = (s > m_ref) ? s - m_ref : m_ref - s;
             if (d <= TOL) begin m_mc++; m_sum += s; end
             else begin m_ref = s; m_mc = 1; m_sum = s; end
             if (m_mc >= SETTLE_N) begin
               m_st = 2; m_w = AVG ? m_sum / SETTLE_N : m_ref; m_wv = 1; m_mc = 0; m_tmo = 0;
             end else if (m_tmo >= SETTLE_TIMEOUT) begin
               m_st = 3; ue = 1; m_mc = 0; m_tmo = 0;
             end
           end
        default: if (s < EMPTY_TH) begin
             m_ec++;
             if (m_ec >= EMPTY_N) begin
               pd = (m_st == 2); m_st = 0; m_ec = 0; m_w = 0; m_wv = 0;
             end
           end else m_ec = 0;
      endcase
    end
    e.w = W'(m_w); e.wv = m_wv[0]; e.pd = pd; e.ue = ue; e.st = 2'(m_st);
    sb.push_back(e);
  endfunction

  task automatic step(input bit rst, input bit v, input int s);
    exp_t e;
    reset = rst; sample_valid = v; sample = W'(s);
    model(rst, v, s);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (weight !== e.w) begin errors++; $display("FAIL sb_weight got %0d exp %0d s=%0d", weight, e.w, s); end
    checks++;
    if (weight_valid !== e.wv) begin errors++; $display("FAIL sb_wvalid got %0b exp %0b s=%0d", weight_valid, e.wv, s); end
    checks++;
    if (pkg_done !== e.pd) begin errors++; $display("FAIL sb_pkg_done got %0b exp %0b s=%0d", pkg_done, e.pd, s); end
    checks++;
    if (unstable_err !== e.ue) begin errors++; $display("FAIL sb_unstable got %0b exp %0b s=%0d", unstable_err, e.ue, s); end
    checks++;
    if (state_dbg !== e.st) begin errors++; $display("FAIL sb_state got %0d exp %0d s=%0d", state_dbg, e.st, s); end
    pd_cnt += int'(pkg_done);
    ue_cnt += int'(unstable_err);
  endtask

  task automatic test_reset;
    step(1, 0, 0);
    step(1, 1, 300);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 5);
    checks++;
    if (weight !== 0 || weight_valid !== 0 || state_dbg !== 0) begin
      errors++; $display("FAIL reset_idle got w=%0d wv=%0b st=%0d exp 0 0 0", weight, weight_valid, state_dbg);
    end
  endtask

  task automatic test_settle_depart;
    int exp_w;
    exp_w = AVG ? 250 : 248;
    pd_cnt = 0;
    step(0, 1, 248); step(0, 1, 252); step(0, 1, 250); step(0, 1, 250);
    checks++;
    if (weight !== W'(exp_w) || weight_valid !== 1'b1) begin
      errors++; $display("FAIL settle_weight got %0d/%0b exp %0d/1", weight, weight_valid, exp_w);
    end
    step(0, 1, 0); step(0, 1, 0);
    checks++;
    if (pd_cnt != 1 || weight !== 0) begin
      errors++; $display("FAIL pkg_done_once got pulses=%0d w=%0d exp 1 0", pd_cnt, weight);
    end
  endtask

  task automatic test_timeout;
    ue_cnt = 0; pd_cnt = 0;
    for (int i = 0; i < SETTLE_TIMEOUT; i++) step(0, 1, (i % 2) ? 320 : 300);
    checks++;
    if (ue_cnt != 1 || weight !== 0 || state_dbg !== 2'd3) begin
      errors++; $display("FAIL timeout got ue=%0d w=%0d st=%0d exp 1 0 3", ue_cnt, weight, state_dbg);
    end
    step(0, 1, 0); step(0, 1, 0);
    checks++;
    if (state_dbg !== 2'd0 || pd_cnt != 0) begin
      errors++; $display("FAIL depart_empty got st=%0d pd=%0d exp 0 0", state_dbg, pd_cnt);
    end
  endtask

  task automatic test_valid_gaps;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 550);
      checks++;
      if ((state_dbg == 2'd2) != (i == 3)) begin
        errors++; $display("FAIL gap_state got st=%0d exp stable=%0d at %0d", state_dbg, i == 3, i);
      end
      if (i < 3) for (int j = 0; j < 3; j++) step(0, 0, (j == 1) ? 0 : 900);
    end
    step(0, 1, 0); step(0, 1, 0);
  endtask

  task automatic test_empty_clear;
    pd_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 801);
    step(0, 1, 0); step(0, 1, 500); step(0, 1, 0);
    checks++;
    if (pd_cnt != 0 || weight_valid !== 1'b1) begin
      errors++; $display("FAIL empty_cnt_clear got pd=%0d wv=%0b exp 0 1", pd_cnt, weight_valid);
    end
    step(0, 1, 0);
    checks++;
    if (pd_cnt != 1 || pkg_done !== 1'b1) begin
      errors++; $display("FAIL final_pkg_done got pd=%0d exp 1", pd_cnt);
    end
  endtask

  task automatic test_mid_reset;
    pd_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 1001);
    checks++;
    if (weight !== W'(1001)) begin errors++; $display("FAIL pre_reset_w got %0d exp 1001", weight); end
    step(1, 1, 0);
    checks++;
    if (weight !== 0 || weight_valid !== 0 || pd_cnt != 0) begin
      errors++; $display("FAIL mid_reset got w=%0d wv=%0b pd=%0d exp 0 0 0", weight, weight_valid, pd_cnt);
    end
    step(0, 1, 0); step(0, 1, 0);
  endtask

  initial begin
    pd_cnt = 0; ue_cnt = 0;
    test_reset();
    test_settle_depart();
    test_timeout();
    test_valid_gaps();
    test_empty_clear();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
